// File: rtl/code_stim_driver.sv
// code_stim_driver: command-driven Slt/En/CntReset generator for the dual event counter; STIM_IDLE_GAP_EN inserts an En=0 gap cycle after each En cycle.
module code_stim_driver #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdOp,
  input  logic [CNT_W-1:0] CmdN0,
  input  logic [CNT_W-1:0] CmdN1,
  output logic             Slt,
  output logic             En,
  output logic             CntReset,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       Phase
);
`ifdef STIM_IDLE_GAP_EN
  localparam logic GAP = 1'b1;
`else
  localparam logic GAP = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, CLR, RUN0, RUN1, DONE} state_t;
  state_t state, nstate;
  logic gap, ngap, run_q, nrun;
  logic [CNT_W-1:0] rem0, rem1, nrem0, nrem1;
  logic [1:0] nphase;
  function automatic state_t entry(input logic [CNT_W-1:0] r0, input logic [CNT_W-1:0] r1);
    return r0 != '0 ? RUN0 : r1 != '0 ? RUN1 : DONE;
  endfunction
  // next state, remaining counts and shadow phase; a gap cycle only clears the gap flag
  always_comb begin
    nstate = state;
    ngap = 1'b0;
    nrun = run_q;
    nrem0 = rem0;
    nrem1 = rem1;
    nphase = Phase;
    case (state)
      IDLE: if (CmdValid) begin
        nrem0 = CmdN0;
        nrem1 = CmdN1;
        nrun = CmdOp[1];
        nstate = CmdOp == 2'b00 ? DONE : CmdOp[0] ? CLR : entry(CmdN0, CmdN1);
      end
      CLR: begin
        nphase = 2'd0;
        nstate = run_q ? entry(rem0, rem1) : DONE;
      end
      RUN0: if (!gap) begin
        nrem0 = rem0 - 1'b1;
        nstate = rem0 != CNT_W'(1) ? RUN0 : rem1 != '0 ? RUN1 : DONE;
        ngap = GAP && nstate != DONE;
      end
      RUN1: if (!gap) begin
        nphase = Phase + 2'd1;
        nrem1 = Phase == 2'd3 ? rem1 - 1'b1 : rem1;
        nstate = Phase == 2'd3 && rem1 == CNT_W'(1) ? DONE : RUN1;
        ngap = GAP && nstate != DONE;
      end
      DONE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  // state and registered outputs decoded from the upcoming state
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      gap <= 1'b0;
      run_q <= 1'b0;
      rem0 <= '0;
      rem1 <= '0;
      Phase <= 2'd0;
      Slt <= 1'b0;
      En <= 1'b0;
      CntReset <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
      CmdReady <= 1'b1;
    end else begin
      state <= nstate;
      gap <= ngap;
      run_q <= nrun;
      rem0 <= nrem0;
      rem1 <= nrem1;
      Phase <= nphase;
      Slt <= ngap ? Slt : nstate == RUN1;
      En <= (nstate == RUN0 || nstate == RUN1) && !ngap;
      CntReset <= nstate == CLR;
      Busy <= nstate != IDLE;
      Done <= nstate == DONE;
      CmdReady <= nstate == IDLE;
    end
  end
endmodule

// File: tb/tb_code_stim_driver.sv
// tb_code_stim_driver: directed bench for code_stim_driver with a behavioural dual event counter on its outputs.
module tb_code_stim_driver;
`ifdef STIM_IDLE_GAP_EN
  localparam bit G = 1'b1;
`else
  localparam bit G = 1'b0;
`endif
  logic Clk = 1'b0, Reset = 1'b1, CmdValid = 1'b0, CmdReady;
  logic [1:0] CmdOp = 2'b00;
  logic [15:0] CmdN0 = '0, CmdN1 = '0;
  logic Slt, En, CntReset, Busy, Done;
  logic [1:0] Phase;
  logic ovr = 1'b0, t_en = 1'b0, t_slt = 1'b0;
  int c_out0 = 0, c_out1 = 0;
  logic [1:0] c_ph = 2'd0;
  int n_cmp = 0, n_bad = 0;
  int k, ens, crs;

  code_stim_driver #(.CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady), .CmdOp(CmdOp),
    .CmdN0(CmdN0), .CmdN1(CmdN1), .Slt(Slt), .En(En), .CntReset(CntReset),
    .Busy(Busy), .Done(Done), .Phase(Phase)
  );

  always #5 Clk = ~Clk;

  // reference dual event counter fed by the DUT or by bench override
  always @(posedge Clk) begin
    if (Reset || CntReset) begin
      c_out0 <= 0;
      c_out1 <= 0;
      c_ph <= 2'd0;
    end else if (ovr ? t_en : En) begin
      if (!(ovr ? t_slt : Slt)) c_out0 <= c_out0 + 1;
      else begin
        c_ph <= c_ph + 2'd1;
        if (c_ph == 2'd3) c_out1 <= c_out1 + 1;
      end
    end
  end

  function automatic int run_len(input int e);
    return e == 0 ? 0 : (G ? 2 * e - 1 : e);
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input int n0, input int n1);
    int n;
    @(posedge Clk); #1;
    CmdValid = 1'b1; CmdOp = op; CmdN0 = 16'(n0); CmdN1 = 16'(n1);
    n = 0;
    while (!CmdReady && n < 100) begin
      @(posedge Clk); #1;
      n++;
    end
    check("ready_before_accept", CmdReady, 1);
    @(posedge Clk); #1;
    CmdValid = 1'b0; CmdN0 = 16'hdead; CmdN1 = 16'hbeef;
  endtask

  task automatic wait_done(output int kd, output int en_n, output int cr_n);
    kd = 0; en_n = 0; cr_n = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge Clk);
      if (En) en_n++;
      if (CntReset) cr_n++;
      if (Done) begin
        kd = i;
        break;
      end
    end
    if (kd == 0) check("done_timeout", 0, 1);
  endtask

  task automatic cmd(input logic [1:0] op, input int n0, input int n1, input string tag, input int exp_k, input int exp_en, input int exp_cr);
    issue(op, n0, n1);
    wait_done(k, ens, crs);
    check({tag, "_done_cycle"}, k, exp_k);
    check({tag, "_en_cycles"}, ens, exp_en);
    check({tag, "_cntreset"}, crs, exp_cr);
  endtask

  initial begin
    int acc_n, a2, dj, dn;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check("rst_en", En, 0);
    check("rst_slt", Slt, 0);
    check("rst_cntreset", CntReset, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_phase", Phase, 0);
    check("rst_ready", CmdReady, 1);

    cmd(2'b10, 3, 2, "t1", 1 + run_len(11), 11, 0);
    check("t1_out0", c_out0, 3);
    check("t1_out1", c_out1, 2);
    check("t1_phase", Phase, 0);
    check("t1_cph", c_ph, 0);

    @(posedge Clk); #1;
    ovr = 1'b1; t_en = 1'b1; t_slt = 1'b1;
    repeat (2) @(posedge Clk);
    #1 ovr = 1'b0; t_en = 1'b0; t_slt = 1'b0;
    check("t2_cph_forced", c_ph, 2);
    check("t2_phase_untouched", Phase, 0);
    cmd(2'b01, 7, 7, "t2clr", 2, 0, 1);
    check("t2_clr_out0", c_out0, 0);
    check("t2_clr_cph", c_ph, 0);
    cmd(2'b10, 0, 1, "t2run", 1 + run_len(4), 4, 0);
    check("t2_out1", c_out1, 1);
    check("t2_phase", Phase, c_ph);

    cmd(2'b10, 9, 0, "t3pre", 1 + run_len(9), 9, 0);
    check("t3pre_out0", c_out0, 9);
    cmd(2'b11, 5, 0, "t3", 2 + run_len(5), 5, 1);
    check("t3_out0", c_out0, 5);
    check("t3_out1", c_out1, 0);

    cmd(2'b00, 4, 4, "t4nop", 1, 0, 0);
    cmd(2'b10, 0, 0, "t4zero", 1, 0, 0);
    check("t4_out0", c_out0, 5);
    check("t4_out1", c_out1, 0);

    issue(2'b10, 0, 5);
    repeat (G ? 17 : 9) @(posedge Clk);
    #1 Reset = 1'b1;
    check("t5_mid_busy", Busy, 1);
    check("t5_mid_en_slt", En && Slt || G, 1);
    @(posedge Clk); #1;
    Reset = 1'b0;
    check("t5_en", En, 0);
    check("t5_busy", Busy, 0);
    check("t5_done", Done, 0);
    check("t5_phase", Phase, 0);
    dn = 0;
    repeat (6) begin
      @(negedge Clk);
      if (Done || En) dn++;
    end
    check("t5_no_done_after", dn, 0);

    @(posedge Clk); #1;
    CmdValid = 1'b1; CmdOp = 2'b10; CmdN0 = 16'd2; CmdN1 = 16'd0;
    acc_n = 0; a2 = 0; dj = 0;
    for (int j = 1; j <= 3 + run_len(2); j++) begin
      @(negedge Clk);
      if (Done) dj = j;
      if (CmdValid && CmdReady) begin
        if (acc_n == 1) a2 = j;
        acc_n++;
      end
    end
    @(posedge Clk); #1 CmdValid = 1'b0;
    check("t6_accepts", acc_n, 2);
    check("t6_done_cycle", dj, 2 + run_len(2));
    check("t6_second_accept", a2, 3 + run_len(2));
    wait_done(k, ens, crs);
    check("t6_second_en", ens, 2);
    check("t6_out0", c_out0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
